button_debounce_counter: RTL

- Parametrised multi-channel successor to the single-button debounce/2-bit press counter.
- Per channel: raw pushbutton input is synchronised, then debounced by sampling on a shared prescaled tick and requiring N consecutive stable samples.
- Outputs per channel: debounced level, press/release pulses and a configurable-width press counter (wrap or saturate).
- Sits between board pushbuttons and the control FSMs; replaces the clock-divider-clocked flip-flop chain with a single-clock design.

---
 rtl/button_debounce_counter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/button_debounce_counter.sv
// rtl/button_debounce_counter.sv - multi-channel pushbutton debouncer with press counters (optional BUTTON_LONG_PRESS_EN)
module button_debounce_counter #(
  parameter int CHANNELS       = 4,
  parameter int CNT_WIDTH      = 2,
  parameter int TICK_DIV       = 50000,
  parameter int STABLE_SAMPLES = 4,
  parameter int SATURATE       = 0,
  parameter int LONG_SAMPLES   = 100
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic                          enable_i,
  input  logic [CHANNELS-1:0]           btn_i,
  input  logic [CHANNELS-1:0]           clear_i,
  output logic [CHANNELS-1:0]           level_o,
  output logic [CHANNELS-1:0]           press_o,
  output logic [CHANNELS-1:0]           release_o,
  output logic [CHANNELS*CNT_WIDTH-1:0] count_o,
  output logic [CHANNELS-1:0]           long_press_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(STABLE_SAMPLES + 1);
  localparam logic [PW-1:0]        PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0]        STAB_LAST  = SW'(STABLE_SAMPLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_CONFIRM = 1'b1
  } state_e;

  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;
  logic [PW-1:0]       presc_q;
  logic [PW-1:0]       presc_d;
  logic                tick;

  // Two-flop synchroniser for the asynchronous button inputs; always running
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Prescaler next state: wraps at TICK_DIV-1, holds its value while disabled
  always_comb begin
    presc_d = presc_q;
    if (enable_i) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    end
  end

  // Prescaler register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick = enable_i && (presc_q == PRESC_LAST);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_e                 state_q;
    logic [SW-1:0]          stab_q;
    logic                   level_q;
    logic                   press_q;
    logic                   release_q;
    logic [CNT_WIDTH-1:0]   count_q;
    logic                   differ;
    logic                   commit;

    assign differ = (sync2_q[g] != level_q);
    // A commit is the tick on which the last required differing sample arrives
    assign commit = tick && differ &&
                    (((state_q == ST_CONFIRM) && ((stab_q + 1'b1) == STAB_LAST)) ||
                     ((state_q == ST_STABLE) && (STABLE_SAMPLES == 1)));

    // Debounce FSM: counts consecutive differing samples and toggles the level on commit
    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        state_q   <= ST_STABLE;
        stab_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (tick) begin
          if (commit) begin
            level_q   <= ~level_q;
            press_q   <= ~level_q;
            release_q <= level_q;
            state_q   <= ST_STABLE;
            stab_q    <= '0;
          end else if (!differ) begin
            state_q <= ST_STABLE;
            stab_q  <= '0;
          end else begin
            state_q <= ST_CONFIRM;
            stab_q  <= stab_q + 1'b1;
          end
        end
      end
    end

    // Press counter: clear has priority over a coincident press
    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        count_q <= '0;
      end else if (clear_i[g]) begin
        count_q <= '0;
      end else if (commit && !level_q) begin
        if ((SATURATE == 0) || (count_q != CNT_MAX)) begin
          count_q <= count_q + 1'b1;
        end
      end
    end

    assign level_o[g]                            = level_q;
    assign press_o[g]                            = press_q & enable_i;
    assign release_o[g]                          = release_q & enable_i;
    assign count_o[g*CNT_WIDTH +: CNT_WIDTH]     = count_q;

`ifdef BUTTON_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_SAMPLES + 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_SAMPLES);
    logic [LW-1:0] long_cnt_q;
    logic          long_q;

    // Long-press timer: restarts on every level change, fires once then parks
    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        long_cnt_q <= '0;
        long_q     <= 1'b0;
      end else begin
        long_q <= 1'b0;
        if (commit) begin
          long_cnt_q <= '0;
        end else if (tick && level_q && (long_cnt_q != LONG_LAST)) begin
          long_cnt_q <= long_cnt_q + 1'b1;
          if ((long_cnt_q + 1'b1) == LONG_LAST) begin
            long_q <= 1'b1;
          end
        end
      end
    end

    assign long_press_o[g] = long_q & enable_i;
`else
    assign long_press_o[g] = 1'b0;
`endif
  end

endmodule
